// File: rtl/dm_cache_pkg.sv
// cache_types: shared types and geometry for the direct-mapped cache.
//   cache_state_t  - controller states
//   cache_line_t   - one 32-byte cache line
//   OFFSET_W       - byte-offset bits within a line
//   tag_width()    - tag bits for a given number of index bits
package cache_types;

    typedef enum logic [1:0] {
        CHECK,
        RESP,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    typedef logic [255:0] cache_line_t;

    localparam int unsigned OFFSET_W = 5;

    function automatic int unsigned tag_width(input int unsigned s_index);
        return 32 - OFFSET_W - s_index;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// cache_array: WIDTH x DEPTH flop array, one shared read/write address,
// combinational read, synchronous write, contents cleared on reset.
//   clk   - clock
//   rst   - asynchronous active-low reset
//   we    - write enable
//   addr  - entry select (read and write)
//   wdata - write data
//   rdata - contents of entry addr
module cache_array #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate cache between a
// 32-bit CPU port and a 256-bit line-burst physical memory.
//   clk, rst                 - clock, asynchronous active-low reset
//   mem_read/mem_write       - CPU request, held until mem_resp
//   mem_byte_enable          - write byte lanes
//   mem_address/mem_wdata    - CPU byte address / write data
//   mem_rdata/mem_resp       - registered read data / one-cycle completion
//   pmem_read/pmem_write     - line fill / line writeback request
//   pmem_address/pmem_wdata  - line address / writeback line
//   pmem_rdata/pmem_resp     - fill line / physical transaction done
module dm_cache
    import cache_types::*;
#(
    parameter int unsigned S_INDEX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned TAG_W = tag_width(S_INDEX);
    localparam int unsigned SETS  = 1 << S_INDEX;

    cache_state_t state, next_state;

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] idx;
    logic [2:0]         word_sel;
    logic [1:0]         unused_byte_offset;

    logic               valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q;
    cache_line_t        line_q;

    logic               valid_we, valid_d;
    logic               dirty_we, dirty_d;
    logic               tag_we;
    logic               data_we;
    cache_line_t        data_d;

    logic               hit, request, load_rdata;
    logic [31:0]        sel_word, merged_word;
    cache_line_t        merged_line;

    assign req_tag            = mem_address[31 -: TAG_W];
    assign idx                = mem_address[OFFSET_W +: S_INDEX];
    assign word_sel           = mem_address[4:2];
    assign unused_byte_offset = mem_address[1:0];

    cache_array #(.WIDTH(1), .DEPTH(SETS)) valid_array (
        .clk(clk), .rst(rst), .we(valid_we), .addr(idx), .wdata(valid_d), .rdata(valid_q)
    );

    cache_array #(.WIDTH(1), .DEPTH(SETS)) dirty_array (
        .clk(clk), .rst(rst), .we(dirty_we), .addr(idx), .wdata(dirty_d), .rdata(dirty_q)
    );

    cache_array #(.WIDTH(TAG_W), .DEPTH(SETS)) tag_array (
        .clk(clk), .rst(rst), .we(tag_we), .addr(idx), .wdata(req_tag), .rdata(tag_q)
    );

    cache_array #(.WIDTH(256), .DEPTH(SETS)) data_array (
        .clk(clk), .rst(rst), .we(data_we), .addr(idx), .wdata(data_d), .rdata(line_q)
    );

    assign request = mem_read | mem_write;
    assign hit     = valid_q && (tag_q == req_tag);

    // Byte-lane merge of the CPU write into the selected word of the line.
    always_comb begin
        sel_word    = line_q[{word_sel, 5'b0} +: 32];
        merged_word = sel_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
        merged_line = line_q;
        merged_line[{word_sel, 5'b0} +: 32] = merged_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CHECK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        valid_we     = 1'b0;
        valid_d      = 1'b0;
        dirty_we     = 1'b0;
        dirty_d      = 1'b0;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        data_d       = line_q;
        load_rdata   = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = line_q;

        case (state)
            CHECK: begin
                if (request) begin
                    if (hit) begin
                        next_state = RESP;
                        // Write wins when both request lines are raised.
                        if (mem_write) begin
                            data_we  = 1'b1;
                            data_d   = merged_line;
                            dirty_we = 1'b1;
                            dirty_d  = 1'b1;
                        end else begin
                            load_rdata = 1'b1;
                        end
                    end else if (valid_q && dirty_q) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end
            RESP: begin
                mem_resp   = 1'b1;
                next_state = CHECK;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, idx, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    dirty_we   = 1'b1;
                    dirty_d    = 1'b0;
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, {OFFSET_W{1'b0}}};
                if (pmem_resp) begin
                    data_we    = 1'b1;
                    data_d     = pmem_rdata;
                    tag_we     = 1'b1;
                    valid_we   = 1'b1;
                    valid_d    = 1'b1;
                    dirty_we   = 1'b1;
                    dirty_d    = 1'b0;
                    next_state = CHECK;
                end
            end
            default: next_state = CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata <= '0;
        end else if (load_rdata) begin
            mem_rdata <= sel_word;
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
module tb_dm_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    dm_cache #(.S_INDEX(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Physical memory: 4 KB = 128 lines; untouched lines hold a fixed pattern.
    logic [255:0] pmem_mem [128];
    bit           written  [128];
    int           lat = 0;
    int           fills = 0, wbs = 0;
    logic [31:0]  last_fill_addr = '0, last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;

    function automatic logic [31:0] init_word(input int k);
        if (k == 17) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ (32'(k) * 32'h00010001);
    endfunction

    function automatic logic [255:0] phys_line(input int i);
        logic [255:0] l;
        if (written[i]) return pmem_mem[i];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(i*8 + w);
        return l;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_resp <= 1'b0;
            lat       <= 0;
        end else begin
            pmem_resp <= 1'b0;
            if ((pmem_read || pmem_write) && !pmem_resp) begin
                if (lat == 2) begin
                    pmem_resp <= 1'b1;
                    lat       <= 0;
                    if (pmem_write) begin
                        pmem_mem[pmem_address[11:5]] <= pmem_wdata;
                        written[pmem_address[11:5]]  <= 1'b1;
                        wbs          <= wbs + 1;
                        last_wb_addr <= pmem_address;
                        last_wb_data <= pmem_wdata;
                    end else begin
                        pmem_rdata     <= phys_line(int'(pmem_address[11:5]));
                        fills          <= fills + 1;
                        last_fill_addr <= pmem_address;
                    end
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    int resp_count = 0;
    always @(posedge clk) begin
        if (rst && mem_resp) resp_count <= resp_count + 1;
    end

    // CPU-visible reference memory and scoreboard of expected read data.
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q [$];
    int          reqs = 0;

    task automatic resync_ref();
        logic [255:0] l;
        for (int i = 0; i < 128; i++) begin
            l = phys_line(i);
            for (int w = 0; w < 8; w++) ref_mem[i*8 + w] = l[w*32 +: 32];
        end
    endtask

    task automatic cpu_req(input bit wr, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d);
        int k;
        bit got;
        logic [31:0] e;
        k = int'(a[11:2]);
        @(negedge clk);
        mem_address = a; mem_byte_enable = b; mem_wdata = d;
        mem_write = wr; mem_read = !wr;
        if (wr) begin
            for (int i = 0; i < 4; i++) if (b[i]) ref_mem[k][i*8 +: 8] = d[i*8 +: 8];
        end else begin
            exp_q.push_back(ref_mem[k]);
        end
        reqs++;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
        end
        if (!got) begin
            check("resp_timeout", 32'(got), 32'd1);
            if (!wr) e = exp_q.pop_front();
        end else if (!wr) begin
            e = exp_q.pop_front();
            check("rdata", mem_rdata, e);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("resp_single_cycle", 32'(mem_resp), 32'd0);
    endtask

    initial begin
        logic [255:0] l;
        int f, w;
        bit seen;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_address = '0; mem_wdata = '0;
        resync_ref();
        repeat (3) @(negedge clk);
        check("rst_mem_resp",   32'(mem_resp),   32'd0);
        check("rst_pmem_read",  32'(pmem_read),  32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_mem_rdata",  mem_rdata,       32'd0);
        check("rst_pmem_addr",  pmem_address,    32'd0);
        rst = 1'b1;

        // Cold miss then hit in the same line.
        cpu_req(1'b0, 32'h40, 4'h0, 32'h0);
        check("fill_count_1", 32'(fills), 32'd1);
        check("fill_addr_1", last_fill_addr, 32'h40);
        cpu_req(1'b0, 32'h44, 4'h0, 32'h0);
        check("hit_no_fill", 32'(fills), 32'd1);

        // Partial write hit, then read back the merged word.
        cpu_req(1'b1, 32'h44, 4'b0011, 32'h11223344);
        cpu_req(1'b0, 32'h44, 4'h0, 32'h0);
        check("write_hit_no_pmem", 32'(fills + wbs), 32'd1);

        // Dirty conflict miss.
        cpu_req(1'b0, 32'h140, 4'h0, 32'h0);
        check("wb_count_1", 32'(wbs), 32'd1);
        check("wb_addr_1", last_wb_addr, 32'h40);
        l = last_wb_data;
        check("wb_word1", l[63:32], 32'hDEAD3344);
        check("fill_count_2", 32'(fills), 32'd2);
        check("fill_addr_2", last_fill_addr, 32'h140);

        // Clean conflict miss: fill only.
        cpu_req(1'b0, 32'h40, 4'h0, 32'h0);
        check("clean_miss_no_wb", 32'(wbs), 32'd1);
        check("fill_count_3", 32'(fills), 32'd3);

        // Zero byte-enable write still marks the line dirty.
        cpu_req(1'b1, 32'h48, 4'b0000, 32'hFFFFFFFF);
        cpu_req(1'b0, 32'h148, 4'h0, 32'h0);
        check("be0_dirty_wb", 32'(wbs), 32'd2);
        check("be0_wb_addr", last_wb_addr, 32'h40);

        // Reset during ALLOCATE aborts the fill immediately.
        @(negedge clk);
        mem_address = 32'h200; mem_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        check("alloc_started", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_abort_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_abort_mem_resp",  32'(mem_resp),  32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        resync_ref();
        f = fills;
        cpu_req(1'b0, 32'h200, 4'h0, 32'h0);
        check("reread_after_rst_misses", 32'(fills), 32'(f + 1));

        // Random traffic over 4 KB.
        for (int n = 0; n < 300; n++) begin
            w = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1)
                cpu_req(1'b1, 32'(w) << 2, 4'($urandom_range(0, 15)), $urandom);
            else
                cpu_req(1'b0, 32'(w) << 2, 4'h0, 32'h0);
        end

        @(negedge clk);
        check("resp_per_request", 32'(resp_count), 32'(reqs));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-back, write-allocate cache between the RV32I core's 32-bit memory port and the 256-bit burst physical memory. It sits directly downstream of the CPU top level. It accepts the core's `mem_read`/`mem_write`/`mem_byte_enable`/`mem_address`/`mem_wdata` request, which is held until `mem_resp`. It returns `mem_rdata`/`mem_resp` and issues whole-line reads and writebacks on the physical side.

## Interface
- `S_INDEX`, default 3: index bits, giving 2^S_INDEX sets.
- Line size is fixed at 256 bits (32 B); offset bits = 5; tag width = 27 − S_INDEX.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `mem_read` input 1: CPU read request; held until `mem_resp`.
- `mem_write` input 1: CPU write request; held until `mem_resp`.
- `mem_byte_enable` input 4: write byte lanes.
- `mem_address` input 32: byte address; bits [1:0] are ignored.
- `mem_wdata` input 32: CPU write data.
- `mem_rdata` output 32: read data; valid when `mem_resp`=1.
- `mem_resp` output 1: one-cycle completion pulse.
- `pmem_read` output 1: line fill request.
- `pmem_write` output 1: line writeback request.
- `pmem_address` output 32: line address, low 5 bits = 0.
- `pmem_wdata` output 256: writeback line.
- `pmem_rdata` input 256: fill line.
- `pmem_resp` input 1: physical transaction done.

## Operation
- Per-set storage: `valid`, `dirty`, tag, 256-bit data. Address split is {tag, index[S_INDEX], offset[5]}; the word select is offset[4:2].
- FSM states: CHECK, RESP, WRITEBACK, ALLOCATE.
- CHECK, no request: idle.
- CHECK, request and hit (valid && tag match):
  - Read: register the selected word into `mem_rdata`.
  - Write: merge `mem_wdata` bytes per `mem_byte_enable` into the word and set `dirty`=1.
  - Next state: RESP.
- CHECK, request and miss:
  - Go to WRITEBACK if valid && dirty.
  - Otherwise go to ALLOCATE.
- RESP: `mem_resp`=1 for exactly one cycle, then return to CHECK.
- WRITEBACK: drive `pmem_write`=1, `pmem_address`={old tag, index, 5'b0}, and `pmem_wdata`=line. Hold all three until `pmem_resp`. Then clear `dirty` and go to ALLOCATE.
- ALLOCATE: drive `pmem_read`=1 and `pmem_address`={req tag, index, 5'b0}, held until `pmem_resp`. On `pmem_resp`, write `pmem_rdata` into the line, set tag, `valid`=1, `dirty`=0, and return to CHECK. The re-lookup then hits.
- `mem_read` && `mem_write` together is illegal; write takes priority.
- `pmem_resp` in CHECK or RESP is ignored.
- `mem_byte_enable`=0 on a write hit: no data change, but `dirty` is still set and `mem_resp` is still issued.

## Timing
- Reset (`rst`=0, asynchronous):
  - State → CHECK.
  - All `valid` and `dirty` bits → 0.
  - `mem_resp`, `pmem_read`, `pmem_write` → 0; `mem_rdata` → 0; `pmem_address` → 0.
  - Tag and data contents are undefined.
- Reset mid-WRITEBACK or mid-ALLOCATE aborts the transaction immediately; the line is lost. This is accepted behaviour.
- Hit latency: request sampled in CHECK at edge N; `mem_resp` is high during cycle N+1. The CPU drops its request after that cycle, so CHECK sees no request at N+2.
- Clean miss: 1 (CHECK) + fill cycles + 1 (CHECK re-lookup) + 1 (RESP).
- Dirty miss additionally costs writeback cycles + 1.
- `pmem_*` outputs are functions of state and registered/array values only, never of `pmem_resp`.
- Back-to-back requests in the same set are allowed with no bubble beyond RESP.

## Structure
- Package `cache_types`:
  - `cache_state_t` enum (CHECK/RESP/WRITEBACK/ALLOCATE).
  - `cache_line_t` (logic [255:0]).
  - Offset-width constant 5.
  - Tag-width function of S_INDEX.
- Sub-module `cache_array`: parameterized width/depth flop array with async active-low reset of contents to 0. Instantiate it for valid, dirty, tag, and data (data uses the same module, with no functional reliance on its reset).
- `dm_cache` itself holds the FSM, hit logic, byte-merge, and registered `mem_rdata`.

## Test plan
- Post-reset read at 0x0000_0040 → `pmem_read` with `pmem_address`=0x0000_0040. Return line with word1=0xDEADBEEF; read of 0x0000_0044 → `mem_rdata`=0xDEADBEEF, `mem_resp` for one cycle, and no further `pmem_read`.
- Write hit at 0x44, data 0x11223344, byte_enable 4'b0011 → a subsequent read returns 0xDEAD3344. The line is dirty and no pmem activity occurs.
- Conflict read at 0x0000_0140 (same index, new tag) after the dirty line → `pmem_write` at 0x0000_0040 whose word1=0xDEAD3344. Then `pmem_read` at 0x0000_0140, then `mem_resp`.
- Clean conflict miss → `pmem_read` only; `pmem_write` never rises.
- Assert `rst`=0 during ALLOCATE with `pmem_resp` pending → `pmem_read` falls in the same cycle. A re-read after reset misses again.
- Random reads/writes over 4 KB against a reference memory model → every `mem_rdata` matches, and each request gets exactly one `mem_resp`.
